// File: rtl/mat_pkg.sv
// mat_pkg: shared widths, limits, table entry layout and FSM states for the matrix store manager.
package mat_pkg;
    localparam int MAX_MATS = 8;
    localparam int ADDR_W = 9;
    localparam int ID_W = 4;
    localparam int DIM_W = 3;
    localparam int AGE_W = 8;
    localparam int IDX_W = 3;
    localparam logic [3:0] MAX_PER_DIM = 4'd2;
    localparam logic [DIM_W-1:0] MAX_DIM = 3'd5;
    localparam logic [9:0] MEM_DEPTH = 10'd512;

    typedef enum logic [2:0] {IDLE, SCAN, DECIDE, GRANT, COOLDOWN, LOOKUP} state_t;

    // reused/age_bk let an aborted reuse restore the entry it borrowed
    typedef struct packed {
        logic valid;
        logic pending;
        logic reused;
        logic [DIM_W-1:0] m;
        logic [DIM_W-1:0] n;
        logic [ADDR_W-1:0] base;
        logic [AGE_W-1:0] age;
        logic [AGE_W-1:0] age_bk;
    } entry_t;

    function automatic logic mat_dims_ok(input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] n);
        return m != '0 && m <= MAX_DIM && n != '0 && n <= MAX_DIM;
    endfunction

    function automatic logic [4:0] mat_area(input logic [DIM_W-1:0] m, input logic [DIM_W-1:0] n);
        return {2'b0, m} * {2'b0, n};
    endfunction
endpackage

// File: rtl/mat_entry_scan.sv
// mat_entry_scan: compares one table entry against the requested (m,n) for the SCAN accumulators.
module mat_entry_scan
    import mat_pkg::*;
(
    input  logic             valid,
    input  logic             pending,
    input  logic [DIM_W-1:0] m,
    input  logic [DIM_W-1:0] n,
    input  logic [AGE_W-1:0] age,
    input  logic [DIM_W-1:0] m_req,
    input  logic [DIM_W-1:0] n_req,
    input  logic             have_old,
    input  logic [AGE_W-1:0] old_age,
    output logic             same_dim,
    output logic             older,
    output logic             free
);
    assign same_dim = (valid || pending) && m == m_req && n == n_req;
    // strict compare keeps the lowest index on equal ages
    assign older = same_dim && (!have_old || age < old_age);
    assign free = !valid && !pending;
endmodule

// File: rtl/mat_store_manager.sv
// mat_store_manager: allocates, commits and looks up matrix regions in the 512-word matrix memory.
// Optional MAT_MGR_STATS_EN adds used_words and mat_count outputs.
module mat_store_manager
    import mat_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              alloc_req,
    input  logic [DIM_W-1:0]  alloc_m,
    input  logic [DIM_W-1:0]  alloc_n,
    input  logic              commit,
    output logic [ADDR_W-1:0] base_addr,
    output logic              addr_ready,
    output logic [ID_W-1:0]   alloc_id,
    output logic              alloc_err,
    input  logic              lkp_req,
    input  logic [ID_W-1:0]   lkp_id,
    output logic              lkp_done,
    output logic              lkp_hit,
    output logic [ADDR_W-1:0] lkp_base,
    output logic [DIM_W-1:0]  lkp_m,
    output logic [DIM_W-1:0]  lkp_n
`ifdef MAT_MGR_STATS_EN
    ,
    output logic [9:0]        used_words,
    output logic [3:0]        mat_count
`endif
);
    state_t state, next_state;
    entry_t tbl [MAX_MATS];
    logic [9:0] free_ptr, rollback;
    logic [AGE_W-1:0] seq, old_age;
    logic [DIM_W-1:0] req_m, req_n;
    logic [IDX_W-1:0] idx, old_idx, free_idx, sel, grant_idx, lkp_idx;
    logic [3:0] cnt;
    logic [ID_W-1:0] lkp_q;
    logic [4:0] size;
    logic have_old, have_free, same_dim, older, is_free, reuse, fits, lkp_ok;

    mat_entry_scan u_scan (
        .valid(tbl[idx].valid),
        .pending(tbl[idx].pending),
        .m(tbl[idx].m),
        .n(tbl[idx].n),
        .age(tbl[idx].age),
        .m_req(req_m),
        .n_req(req_n),
        .have_old(have_old),
        .old_age(old_age),
        .same_dim(same_dim),
        .older(older),
        .free(is_free)
    );

    assign size = mat_area(req_m, req_n);
    assign reuse = cnt >= MAX_PER_DIM;
    assign fits = have_free && (free_ptr + {5'b0, size}) <= MEM_DEPTH;
    assign sel = reuse ? old_idx : free_idx;
    assign lkp_idx = IDX_W'(lkp_q - 4'd1);
    assign lkp_ok = lkp_q != '0 && lkp_q <= ID_W'(MAX_MATS) && tbl[lkp_idx].valid;

    // words held by uncommitted fresh allocations, returned when en drops
    always_comb begin
        rollback = '0;
        for (int i = 0; i < MAX_MATS; i++)
            rollback = rollback + ((tbl[i].pending && !tbl[i].reused) ? {5'b0, mat_area(tbl[i].m, tbl[i].n)} : 10'd0);
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     next_state = alloc_req ? (mat_dims_ok(alloc_m, alloc_n) ? SCAN : COOLDOWN) : (lkp_req ? LOOKUP : IDLE);
            SCAN:     next_state = (idx == IDX_W'(MAX_MATS - 1)) ? DECIDE : SCAN;
            DECIDE:   next_state = (reuse || fits) ? GRANT : COOLDOWN;
            GRANT:    next_state = COOLDOWN;
            COOLDOWN: next_state = alloc_req ? COOLDOWN : IDLE;
            LOOKUP:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        if (!en) next_state = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_MATS; i++) tbl[i] <= '0;
            free_ptr <= '0;
            seq <= '0;
            req_m <= '0;
            req_n <= '0;
            idx <= '0;
            cnt <= '0;
            have_old <= 1'b0;
            have_free <= 1'b0;
            old_idx <= '0;
            old_age <= '0;
            free_idx <= '0;
            grant_idx <= '0;
            lkp_q <= '0;
            base_addr <= '0;
            addr_ready <= 1'b0;
            alloc_id <= '0;
            alloc_err <= 1'b0;
            lkp_done <= 1'b0;
            lkp_hit <= 1'b0;
            lkp_base <= '0;
            lkp_m <= '0;
            lkp_n <= '0;
        end else begin
            addr_ready <= 1'b0;
            alloc_err <= 1'b0;
            lkp_done <= 1'b0;
            if (commit)
                for (int i = 0; i < MAX_MATS; i++)
                    if (tbl[i].pending) begin
                        tbl[i].valid <= 1'b1;
                        tbl[i].pending <= 1'b0;
                        tbl[i].reused <= 1'b0;
                    end
            if (!en) begin
                free_ptr <= free_ptr - rollback;
                for (int i = 0; i < MAX_MATS; i++)
                    if (tbl[i].pending && tbl[i].reused) begin
                        tbl[i].valid <= 1'b1;
                        tbl[i].pending <= 1'b0;
                        tbl[i].reused <= 1'b0;
                        tbl[i].age <= tbl[i].age_bk;
                    end else if (tbl[i].pending) tbl[i] <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        req_m <= alloc_m;
                        req_n <= alloc_n;
                        idx <= '0;
                        cnt <= '0;
                        have_old <= 1'b0;
                        have_free <= 1'b0;
                        lkp_q <= lkp_id;
                        alloc_err <= alloc_req && !mat_dims_ok(alloc_m, alloc_n);
                    end
                    SCAN: begin
                        idx <= idx + 1'b1;
                        cnt <= cnt + {3'b0, same_dim};
                        if (older) begin
                            have_old <= 1'b1;
                            old_idx <= idx;
                            old_age <= tbl[idx].age;
                        end
                        if (is_free && !have_free) begin
                            have_free <= 1'b1;
                            free_idx <= idx;
                        end
                    end
                    DECIDE: begin
                        grant_idx <= sel;
                        alloc_err <= !(reuse || fits);
                        if (reuse || fits) begin
                            tbl[sel].valid <= commit;
                            tbl[sel].pending <= !commit;
                            tbl[sel].age <= seq;
                            if (reuse) begin
                                tbl[sel].reused <= !commit && (tbl[sel].reused || tbl[sel].valid);
                                tbl[sel].age_bk <= tbl[sel].valid ? tbl[sel].age : tbl[sel].age_bk;
                            end else begin
                                tbl[sel].reused <= 1'b0;
                                tbl[sel].m <= req_m;
                                tbl[sel].n <= req_n;
                                tbl[sel].base <= free_ptr[ADDR_W-1:0];
                                free_ptr <= free_ptr + {5'b0, size};
                            end
                        end
                    end
                    GRANT: begin
                        addr_ready <= 1'b1;
                        base_addr <= tbl[grant_idx].base;
                        alloc_id <= {1'b0, grant_idx} + 4'd1;
                        seq <= seq + {7'b0, seq != 8'hff};
                    end
                    LOOKUP: begin
                        lkp_done <= 1'b1;
                        lkp_hit <= lkp_ok;
                        lkp_base <= lkp_ok ? tbl[lkp_idx].base : '0;
                        lkp_m <= lkp_ok ? tbl[lkp_idx].m : '0;
                        lkp_n <= lkp_ok ? tbl[lkp_idx].n : '0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MAT_MGR_STATS_EN
    logic [3:0] n_valid;

    always_comb begin
        n_valid = '0;
        for (int i = 0; i < MAX_MATS; i++) n_valid = n_valid + {3'b0, tbl[i].valid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_words <= '0;
            mat_count <= '0;
        end else begin
            used_words <= free_ptr;
            mat_count <= n_valid;
        end
    end
`endif
endmodule

// File: doc/mat_store_manager.md
Name: mat_store_manager

Overview:
- Allocates and tracks matrix storage regions in the shared 512-word matrix memory.
- Answers the input subsystem's dimension requests with a base address and ready pulse, and commits regions when reception finishes.
- Resolves matrix-ID lookups for the compute/display tasks.
- Sits between the input subsystem and the matrix BRAM address mux.

Parameters:
- MAX_MATS, 8, table entries; matrix IDs are 1..MAX_MATS.
- MAX_PER_DIM, 2, maximum stored matrices per (m,n) pair.
- MEM_DEPTH, 512, words in matrix memory; address width 9.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  input-task enable; low aborts and discards uncommitted allocations
- alloc_req  in  1  level request from input subsystem (dims valid)
- alloc_m  in  3  rows, 1..5
- alloc_n  in  3  cols, 1..5
- commit  in  1  pulse from input subsystem rx_done
- base_addr  out  9  granted region base
- addr_ready  out  1  one-cycle grant pulse
- alloc_id  out  4  ID of granted entry
- alloc_err  out  1  one-cycle pulse: illegal dims or no space
- lkp_req  in  1  lookup pulse
- lkp_id  in  4  ID to resolve
- lkp_done  out  1  one-cycle pulse
- lkp_hit  out  1  entry valid, held until next lookup
- lkp_base  out  9  held with lkp_hit
- lkp_m  out  3  held with lkp_hit
- lkp_n  out  3  held with lkp_hit

Behaviour:
- Reset: all outputs 0, table invalid, free_ptr=0, seq=0, state IDLE.
- Entry fields: valid, pending, m, n, base[8:0], age[7:0].
- States: IDLE, SCAN, DECIDE, GRANT, COOLDOWN, LOOKUP.
- IDLE:
  - alloc_req high -> latch m,n, go to SCAN.
  - Otherwise lkp_req -> LOOKUP.
  - alloc_req has priority when both are high in the same cycle.
- Illegal dims: m or n of 0 or >5 -> alloc_err pulse, then COOLDOWN.
- SCAN: one entry per cycle, MAX_MATS cycles. Records:
  - count of valid or pending entries with equal (m,n);
  - index of the smallest age among them;
  - first free index.
- DECIDE:
  - Same-dim count >= MAX_PER_DIM -> reuse the oldest same-dim entry: same base and ID, mark pending, age=seq.
  - Else, if a free index exists and free_ptr + m*n <= MEM_DEPTH -> new entry: base=free_ptr, free_ptr += m*n, pending.
  - Else alloc_err, then COOLDOWN.
  - m*n is computed at 5 bits; the sum is checked at 10 bits with no wrap.
- GRANT:
  - base_addr and alloc_id are valid the same cycle addr_ready pulses; they are held until the next grant.
  - seq increments and saturates at 255 (ties go to the lowest index).
  - Then COOLDOWN.
- COOLDOWN: stay until alloc_req has been low for at least one cycle, so the requester's stale level cannot cause a double grant. Then IDLE.
  - A generate-mode second matrix arrives as a new alloc_req rising edge and is allocated independently.
- commit: in any state, sets valid and clears pending on all pending entries. If it coincides with a DECIDE write, the new entry is committed too.
- en low: any state -> IDLE the next cycle.
  - Pending non-reused entries are cleared, and free_ptr rolls back by their sizes.
  - Reused entries revert to valid with their old contents (data is stale but the region is intact).
  - Valid entries are kept.
- LOOKUP: one cycle.
  - lkp_hit=1 when 1<=lkp_id<=MAX_MATS and the entry is valid (not merely pending).
  - lkp_done pulses; fields are zeroed on a miss.

Optional Feature:
- MAT_MGR_STATS_EN defined: adds outputs used_words[9:0] (=free_ptr) and mat_count[3:0] (number of valid entries), registered and updated one cycle after each change.
- Absent: these ports and their logic do not exist.

Decomposition:
- Shared package mat_pkg: MAX_DIM=5, MEM_DEPTH, ADDR_W=9, ID_W=4, state encoding localparams, and the entry field widths.
- One natural sub-module, mat_entry_scan: combinational compare of one entry against (m,n), feeding the SCAN accumulator registers.

Test Plan:
- Request 2x3 then commit -> addr_ready with base 0, id 1; request 3x3 -> base 6, id 2; lookup id 2 -> hit, base 6, m=3, n=3.
- Three 2x2 requests, each committed -> bases 0, 4, then 0 reused (id 1, oldest); free_ptr stays 8.
- alloc_req held high for 3 cycles after the grant -> exactly one addr_ready; a new rising edge gives a second grant.
- Request 0x3 or 6x1 -> alloc_err pulse, no table change; fill memory to 500 words then request 5x5 -> alloc_err.
- Grant 4x4 (no commit), drop en -> free_ptr rolls back, lookup of that id misses.
- Lookup id 0, id 9, or a pending id -> lkp_done with lkp_hit=0 and zeroed fields.
